// File: rtl/arb_defs.sv
// rtl/arb_defs.sv - shared state encodings and defaults for the round-robin gate arbiter
package arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker
//   req    : request vector, bit i for requester i
//   ptr    : highest-priority index; search runs ptr, ptr+1, ... wrapping at N-1
//   valid  : at least one request is set
//   idx    : binary index of the chosen requester (0 when none)
//   onehot : one-hot form of idx (0 when none)
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx,
  output logic [N-1:0]   onehot
);

  // Walk offsets from farthest to nearest so the nearest set bit after ptr
  // is the last to write and therefore wins.
  always_comb begin
    int pos;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (req[pos]) begin
        valid       = 1'b1;
        idx         = IDW'(pos);
        onehot      = '0;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_gate_arbiter.sv
// rtl/rr_gate_arbiter.sv - round-robin arbiter for one shared gate resource
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   req     : level-sensitive request per requester
//   done    : current owner finished, releases the grant
//   gnt     : registered one-hot grant (drives datapath mux select)
//   gnt_id  : registered binary index of the owner, 0 when idle
//   busy    : high while a grant is active
//   timeout : one-cycle pulse when a grant is force-released at MAX_HOLD
module rr_gate_arbiter
  import arb_defs::*;
#(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  arb_state_t     state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [7:0]     hold_cnt, hold_n;
  logic [N-1:0]   gnt_n;
  logic [IDW-1:0] gnt_id_n;
  logic           busy_n;
  logic           timeout_n;

  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] ptr_after_owner;
  logic           owner_req;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // gnt_id holds the owner while in GRANT; explicit wrap keeps non-power-of-2 N correct.
  assign ptr_after_owner = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
  assign owner_req       = |(req & gnt);

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    busy_n    = busy;
    timeout_n = 1'b0;
    case (state)
      ST_GRANT: begin
        if (done || !owner_req || (hold_cnt >= 8'(MAX_HOLD))) begin
          // done wins over the hold limit, so timeout only fires on a pure limit release
          timeout_n = !done && owner_req;
          state_n   = ST_RELEASE;
          ptr_n     = ptr_after_owner;
          gnt_n     = '0;
          gnt_id_n  = '0;
          busy_n    = 1'b0;
          hold_n    = '0;
        end else if (hold_cnt != 8'hff) begin
          hold_n = hold_cnt + 8'd1;
        end
      end
      default: begin
        // RELEASE arbitrates exactly like IDLE; its one cycle of gnt=0 is the dead band.
        if (pick_valid) begin
          state_n  = ST_GRANT;
          gnt_n    = pick_onehot;
          gnt_id_n = pick_idx;
          busy_n   = 1'b1;
          hold_n   = 8'd1;
        end else begin
          state_n  = ST_IDLE;
          gnt_n    = '0;
          gnt_id_n = '0;
          busy_n   = 1'b0;
          hold_n   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_rr_gate_arbiter.sv
// tb/tb_rr_gate_arbiter.sv - directed table-driven bench for rr_gate_arbiter
module tb_rr_gate_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  rr_gate_arbiter #(
    .N        (4),
    .IDW      (2),
    .MAX_HOLD (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [3:0] r, input logic d, input logic [3:0] g,
                     input logic [1:0] id, input logic b, input logic t);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g; v.id = id; v.busy = b; v.to = t;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eb, input logic et);
    checks++;
    if (gnt !== eg || gnt_id !== eid || busy !== eb || timeout !== et) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b to=%b, want gnt=%b id=%0d busy=%b to=%b",
               name, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    tick();
    tick();
    check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};

    // Round robin with all requesting: each owner holds two cycles, done in the second.
    foreach (order[i]) begin
      add(4'b1111, 1'b0, 4'(1 << order[i]), 2'(order[i]), 1'b1, 1'b0);
      add(4'b1111, 1'b0, 4'(1 << order[i]), 2'(order[i]), 1'b1, 1'b0);
      add(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Single requester: three grant cycles, release, re-grant, release.
    add(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Wrap past owner 3 and sparse requests.
    add(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    add(4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    add(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
    add(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    // Owner drops req, done while idle, done during RELEASE ignored.
    add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].to);
    end

    // Timeout: owner 0 holds 8 cycles, pulse during RELEASE, then requester 1.
    do_reset();
    req  = 4'b0011;
    done = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("to_hold%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    check("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    check("to_next", 4'b0010, 2'd1, 1'b1, 1'b0);

    // done coincides with hold limit: release without timeout.
    for (int c = 2; c <= 8; c++) tick();
    check("lim_hold8", 4'b0010, 2'd1, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    check("lim_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    tick();
    check("lim_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-grant, then restart from ptr 0.
    req = 4'b0010;
    tick();
    check("rst_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b1000;
    tick();
    check("rst_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 4'b1010;
    tick();
    check("rst_ptr_wrap", 4'b0010, 2'd1, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_gate_arbiter.md
Name: rr_gate_arbiter

Overview:
- Round-robin arbiter that shares one gate-level resource (e.g. an OR/AND gate test slot or shared output line) among N requesters.
- Grants exactly one requester at a time and holds the grant until that requester signals done, drops its request, or exceeds a hold limit.
- Sits between the requester logic and the shared gate datapath. The grant vector drives the datapath input mux select.

Parameters:
- N, 4, number of requesters (2..16)
- IDW, 2, width of grant index; must satisfy 2^IDW >= N
- MAX_HOLD, 8, maximum cycles a grant may be held before forced release (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  N  request per requester, level-sensitive
- done  in  1  current owner finished; releases grant
- gnt  out  N  one-hot grant, registered
- gnt_id  out  IDW  binary index of the granted requester, registered; 0 when idle
- busy  out  1  high while any grant is active
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0. Outputs update immediately on rst assertion, not at the next clock edge.
- States:
  - IDLE: no grant.
  - GRANT: one owner.
  - RELEASE: single dead cycle, gnt=0, guarantees a break-before-make on the shared resource.
- IDLE, at a clk edge with |req=1:
  - Select the first set req bit searching ptr, ptr+1, ..., wrapping modulo N.
  - gnt, gnt_id and busy update at that same edge. Latency from req sampled to gnt visible is 1 cycle.
  - hold_cnt=1. Go to GRANT.
- IDLE with req=0: stay. All outputs 0.
- GRANT, evaluated at each edge in priority order:
  1. done=1 or req[owner]=0: go to RELEASE. ptr=owner+1 mod N.
  2. Otherwise, if hold_cnt==MAX_HOLD: go to RELEASE, timeout=1 for one cycle, ptr=owner+1 mod N.
  3. Otherwise: hold_cnt+=1, grant held.
- done and the timeout condition on the same edge: treated as done, no timeout pulse.
- done while IDLE or RELEASE: ignored.
- RELEASE:
  - gnt=0, gnt_id=0, busy=0.
  - Next edge goes to IDLE arbitration logic directly, i.e. RELEASE behaves as IDLE for selection. A pending req is granted at the edge ending RELEASE.
  - Minimum gap between consecutive grants is 1 cycle.
- Fairness:
  - ptr always points past the last owner.
  - With all N requesting continuously, grant order is 0,1,2,...,N-1,0.
  - No requester waits more than (N-1)·(MAX_HOLD+1) cycles once its req is high.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id == index of the set gnt bit.
  - busy == |gnt.
- req bits above N are nonexistent. ptr wraps with explicit compare to N-1, not power-of-2 truncation.
- hold_cnt width is 8 bits and saturates; it never wraps.
- Reset mid-grant: gnt drops asynchronously. After rst deasserts, arbitration restarts from ptr=0.

Decomposition:
- Shared package/include `arb_defs`:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2.
  - default MAX_HOLD constant.
- One sub-module, `rr_pick`: combinational rotating priority picker.
  - Inputs: req, ptr.
  - Outputs: valid, idx, onehot.
  - Instantiated once in rr_gate_arbiter; the FSM, counter and ptr registers live in the top.

Test Plan:
- Reset: assert rst mid-grant with gnt=4'b0010 -> gnt=0, busy=0 immediately. After release, req=4'b1000 -> gnt=4'b1000, gnt_id=3 one edge later.
- Single requester with done: req=4'b0100, done pulsed 3 cycles after grant -> gnt=4'b0100 for 3 cycles, then one RELEASE cycle with gnt=0, then re-grant to 2 since req is still high.
- Round-robin: req=4'b1111 held, done pulsed every grant's 2nd cycle -> grant sequence 0,1,2,3,0 separated by single zero cycles.
- Timeout: MAX_HOLD=8, req=4'b0011, done never asserted -> gnt=4'b0001 for 8 cycles, timeout pulse 1 cycle, RELEASE, then gnt=4'b0010.
- Simultaneous done and hold limit on the same edge -> release with timeout=0. Owner drops req mid-grant -> release on the next edge.
- Wrap and sparse requests: last owner 3, req=4'b0101 -> next grant goes to 0, not 2. Owner 2 then req=4'b0001 -> grant 0.
